// File: rtl/uart_pkg.sv
// Shared UART definitions: line levels, frame size and receiver state encoding.
package uart_pkg;

   localparam logic UART_IDLE  = 1'b0;
   localparam logic UART_START = 1'b1;
   localparam logic UART_STOP  = 1'b0;
   localparam int   UART_NBITS = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } rx_state_t;

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Bit-period down-counter: loadable, ticks while the count sits at zero.
// With DIV==1 the count is always zero, so tick is constantly high.
module uart_bit_timer #(
   parameter int DIV = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic [$clog2(DIV):0]  load_val,
   output logic                  tick
);

   localparam int CW = $clog2(DIV) + 1;

   logic [CW-1:0] cnt;

   // Count down to zero and park there until the next load
   always_ff @(posedge clk) begin
      if (reset)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (cnt != '0)
         cnt <= cnt - CW'(1);
   end

   assign tick = (cnt == '0);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: idle-low line, start 1, 8 data bits LSB-first, stop 0.
// Emits each good byte with a one-cycle valid strobe and flags bad stop bits.
module uart_rx
   import uart_pkg::*;
#(
   parameter int DIV  = 1,
   parameter int SYNC = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in,
   output logic [7:0] out,
   output logic       valid,
   output logic       ferr,
   output logic       busy
);

   localparam int            CW   = $clog2(DIV) + 1;
   localparam logic [CW-1:0] HALF = CW'((DIV > 1) ? (DIV / 2 - 1) : 0);
   localparam logic [CW-1:0] FULL = CW'(DIV - 1);

   logic          s;
   logic          tick;
   logic          load;
   logic [CW-1:0] load_val;
   rx_state_t     state;
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg;

   generate
      if (SYNC == 0) begin : g_nosync
         assign s = in;
      end else begin : g_sync
         logic [SYNC-1:0] sync_q;

         // Input synchroniser chain; cleared on reset so the line reads idle
         always_ff @(posedge clk) begin
            if (reset) begin
               sync_q <= '0;
            end else begin
               sync_q[0] <= in;
               for (int i = 1; i < SYNC; i++)
                  sync_q[i] <= sync_q[i-1];
            end
         end

         assign s = sync_q[SYNC-1];
      end
   endgenerate

   uart_bit_timer #(.DIV(DIV)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .load_val (load_val),
      .tick     (tick)
   );

   // Timer reload: half a bit after start detection, a full bit after each mid-bit sample
   always_comb begin
      load     = 1'b0;
      load_val = FULL;
      case (state)
         IDLE: begin
            if (s == UART_START) begin
               load     = 1'b1;
               load_val = HALF;
            end
         end
         START, DATA: begin
            if (tick)
               load = 1'b1;
         end
         default: ;
      endcase
   end

   // Frame decoder with registered strobes and byte output
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         out     <= '0;
         valid   <= 1'b0;
         ferr    <= 1'b0;
         busy    <= 1'b0;
         bit_cnt <= '0;
      end else begin
         valid <= 1'b0;
         ferr  <= 1'b0;
         case (state)
            IDLE: begin
               if (s == UART_START) begin
                  busy    <= 1'b1;
                  bit_cnt <= '0;
                  state   <= (DIV == 1) ? DATA : START;
               end
            end
            START: begin
               if (tick) begin
                  if (s == UART_START) begin
                     state <= DATA;
                  end else begin
                     // Start bit gone by mid-bit: treat as a glitch
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            DATA: begin
               if (tick) begin
                  shreg <= {s, shreg[7:1]};
                  if (bit_cnt == 3'(UART_NBITS - 1))
                     state <= STOP;
                  else
                     bit_cnt <= bit_cnt + 3'd1;
               end
            end
            STOP: begin
               if (tick) begin
                  busy <= 1'b0;
                  if (s == UART_STOP) begin
                     out   <= shreg;
                     valid <= 1'b1;
                     state <= IDLE;
                  end else begin
                     ferr  <= 1'b1;
                     state <= BREAK;
                  end
               end
            end
            BREAK: begin
               // Hold off until the line returns idle so a stuck-high line is not re-framed
               if (s == UART_IDLE)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: three instances (DIV=1/SYNC=0, DIV=4/SYNC=0, DIV=1/SYNC=2)
// driven from pre-built line waveforms, checked cycle by cycle against a
// frame-level reference decoder that works directly on the line arrays.
module tb_uart_rx;

   localparam int N = 1000;

   logic clk = 1'b0;
   logic reset;
   logic in1, in4;
   logic [7:0] out0, out1, out2;
   logic valid0, valid1, valid2;
   logic ferr0, ferr1, ferr2;
   logic busy0, busy1, busy2;

   always #5 clk = ~clk;

   uart_rx #(.DIV(1), .SYNC(0)) u_d1 (
      .clk(clk), .reset(reset), .in(in1), .out(out0), .valid(valid0), .ferr(ferr0), .busy(busy0));
   uart_rx #(.DIV(4), .SYNC(0)) u_d4 (
      .clk(clk), .reset(reset), .in(in4), .out(out1), .valid(valid1), .ferr(ferr1), .busy(busy1));
   uart_rx #(.DIV(1), .SYNC(2)) u_s2 (
      .clk(clk), .reset(reset), .in(in1), .out(out2), .valid(valid2), .ferr(ferr2), .busy(busy2));

   // stimulus waveforms (index = cycle)
   bit in1_a [N];
   bit in4_a [N];
   bit rst_a [N];
   int p0, p1;

   // model data per instance
   bit         sv   [3][N];
   bit         ev   [3][N];
   bit         ef   [3][N];
   bit         eb   [3][N];
   logic [7:0] eo   [3][N];
   bit   [1:0] oev  [3][N];
   logic [7:0] oval [3][N];

   int checks = 0;
   int errors = 0;

   int t1, t2, t3, t3c, t4, g, t5, t6, t7;

   task automatic chk(input string nm, input int cyc, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s cycle %0d got %0h expected %0h", nm, cyc, act, exp_v);
      end
   endtask

   task automatic put(input int w, input bit b, input int n);
      for (int i = 0; i < n; i++) begin
         if (w == 0) begin
            if (p0 < N) in1_a[p0] = b;
            p0++;
         end else begin
            if (p1 < N) in4_a[p1] = b;
            p1++;
         end
      end
   endtask

   task automatic frame(input int w, input logic [7:0] d, input bit bad_stop);
      int h;
      h = (w == 0) ? 1 : 4;
      put(w, 1'b1, h);
      for (int i = 0; i < 8; i++) put(w, d[i], h);
      put(w, bad_stop, h);
   endtask

   function automatic bit gs(input int d, input int i);
      if (i < 0 || i >= N) return 1'b0;
      return sv[d][i];
   endfunction

   // Frame-level reference: find starts on the sampled line, read mid-bit
   // samples at fixed offsets, and place the resulting strobes in time.
   task automatic build_model(input int d, input int div, input int sync);
      int c, pos, m0, endc, r, b;
      bit glitch, v;
      logic [7:0] byt, cur;
      for (int i = 0; i < N; i++) begin
         v = 1'b0;
         if (i >= sync) v = (d == 1) ? in4_a[i-sync] : in1_a[i-sync];
         for (int k = 1; k <= sync; k++)
            if (i - k >= 0 && rst_a[i-k]) v = 1'b0;
         sv[d][i] = v;
         ev[d][i] = 1'b0; ef[d][i] = 1'b0; eb[d][i] = 1'b0; oev[d][i] = 2'd0;
      end
      c = 0;
      while (c < N) begin
         if (rst_a[c]) begin
            if (c + 1 < N) oev[d][c+1] = 2'd2;
            c++;
            continue;
         end
         if (!gs(d, c)) begin
            c++;
            continue;
         end
         pos    = c;
         m0     = (div > 1) ? pos + div / 2 : pos;
         glitch = (div > 1) && !gs(d, m0);
         endc   = glitch ? m0 : m0 + 9 * div;
         r = -1;
         for (int k = pos + 1; k <= endc && k < N; k++)
            if (rst_a[k] && r < 0) r = k;
         if (r >= 0) begin
            for (int k = pos + 1; k <= r; k++) eb[d][k] = 1'b1;
            c = r;
            continue;
         end
         for (int k = pos + 1; k <= endc && k < N; k++) eb[d][k] = 1'b1;
         if (glitch) begin
            c = endc + 1;
            continue;
         end
         for (int i = 0; i < 8; i++) byt[i] = gs(d, m0 + div * (i + 1));
         if (endc + 1 >= N) break;
         if (!gs(d, endc)) begin
            ev[d][endc+1]   = 1'b1;
            oev[d][endc+1]  = 2'd1;
            oval[d][endc+1] = byt;
            c = endc + 1;
         end else begin
            ef[d][endc+1] = 1'b1;
            b = endc + 1;
            while (b < N && gs(d, b) && !rst_a[b]) b++;
            c = (b < N && rst_a[b]) ? b : b + 1;
         end
      end
      cur = 8'h00;
      for (int i = 0; i < N; i++) begin
         if (oev[d][i] == 2'd2) cur = 8'h00;
         if (oev[d][i] == 2'd1) cur = oval[d][i];
         eo[d][i] = cur;
      end
   endtask

   initial begin
      int gap, bcount, scount;
      logic [7:0] rb;
      bit bad;

      // ---------------- build stimulus ----------------
      p0 = 0; p1 = 0;
      for (int i = 0; i < 4; i++) rst_a[i] = 1'b1;
      put(0, 1'b0, 8);
      put(1, 1'b0, 8);

      t1 = p0; frame(0, 8'hA9, 1'b0); put(0, 1'b0, 5);
      t7 = p0; frame(0, 8'h5A, 1'b0); put(0, 1'b0, 5);
      t2 = p0; frame(0, 8'hA1, 1'b0); frame(0, 8'hB2, 1'b0); frame(0, 8'hC3, 1'b0); put(0, 1'b0, 3);
      t3 = p0; frame(0, 8'h55, 1'b1); put(0, 1'b1, 3); put(0, 1'b0, 1);
      t3c = p0; frame(0, 8'h3C, 1'b0); put(0, 1'b0, 4);
      t5 = p0; put(0, 1'b1, 1);
      for (int i = 0; i < 5; i++) put(0, rb_bit(8'hE7, i), 1);
      rst_a[t5+5] = 1'b1;
      put(0, 1'b0, 12);
      t6 = p0; frame(0, 8'h81, 1'b0); put(0, 1'b0, 4);
      for (int k = 0; k < 30 && p0 < N - 80; k++) begin
         gap = $urandom_range(0, 2);
         put(0, 1'b0, gap);
         rb  = 8'($urandom);
         bad = ($urandom_range(0, 7) == 0);
         frame(0, rb, bad);
         if (bad) begin
            put(0, 1'b1, $urandom_range(0, 2));
            put(0, 1'b0, 1);
         end
      end

      t4 = p1; frame(1, 8'hD4, 1'b0); put(1, 1'b0, 10);
      g = p1; put(1, 1'b1, 1); put(1, 1'b0, 10);
      for (int k = 0; k < 20 && p1 < N - 80; k++) begin
         put(1, 1'b0, $urandom_range(0, 6));
         if ($urandom_range(0, 4) == 0) begin
            put(1, 1'b1, $urandom_range(1, 2));
            put(1, 1'b0, 4);
         end
         rb  = 8'($urandom);
         bad = ($urandom_range(0, 5) == 0);
         frame(1, rb, bad);
         if (bad) begin
            put(1, 1'b1, $urandom_range(0, 5));
            put(1, 1'b0, 4);
         end
      end

      build_model(0, 1, 0);
      build_model(1, 4, 0);
      build_model(2, 1, 2);

      // ---------------- hand-computed pins on the model ----------------
      chk("pin_a9_valid", t1 + 10, ev[0][t1+10], 1);
      chk("pin_a9_early", t1 + 9, ev[0][t1+9], 0);
      chk("pin_a9_out", t1 + 10, eo[0][t1+10], 8'hA9);
      bcount = 0;
      for (int i = t1; i <= t1 + 11; i++) bcount += eb[0][i];
      chk("pin_a9_busy_len", t1, bcount, 9);
      chk("pin_sync2_a9", t1 + 12, ev[2][t1+12], 1);
      chk("pin_sync2_5a", t7 + 12, eo[2][t7+12], 8'h5A);
      chk("pin_b2b_a1", t2 + 10, eo[0][t2+10], 8'hA1);
      chk("pin_b2b_b2", t2 + 20, ev[0][t2+20] ? eo[0][t2+20] : 0, 8'hB2);
      chk("pin_b2b_c3", t2 + 30, ev[0][t2+30] ? eo[0][t2+30] : 0, 8'hC3);
      chk("pin_ferr", t3 + 10, ef[0][t3+10], 1);
      chk("pin_ferr_noval", t3 + 10, ev[0][t3+10], 0);
      chk("pin_ferr_hold", t3 + 10, eo[0][t3+10], 8'hC3);
      chk("pin_3c", t3c + 10, ev[0][t3c+10] ? eo[0][t3c+10] : 0, 8'h3C);
      chk("pin_d4", t4 + 39, ev[1][t4+39] ? eo[1][t4+39] : 0, 8'hD4);
      chk("pin_glitch_busy", g + 1, eb[1][g+1], 1);
      chk("pin_glitch_idle", g + 3, eb[1][g+3], 0);
      scount = 0;
      for (int i = g; i <= g + 10; i++) scount += ev[1][i] + ef[1][i];
      chk("pin_glitch_nostrobe", g, scount, 0);
      chk("pin_rst_busy", t5 + 6, eb[0][t5+6], 0);
      chk("pin_rst_out", t5 + 6, eo[0][t5+6], 0);
      chk("pin_81", t6 + 10, ev[0][t6+10] ? eo[0][t6+10] : 0, 8'h81);

      // ---------------- drive and compare every cycle ----------------
      in1 = in1_a[0]; in4 = in4_a[0]; reset = rst_a[0];
      for (int c = 1; c < N; c++) begin
         @(posedge clk);
         #1;
         in1 = in1_a[c]; in4 = in4_a[c]; reset = rst_a[c];
         @(negedge clk);
         chk("d1_valid", c, valid0, ev[0][c]);
         chk("d1_ferr",  c, ferr0,  ef[0][c]);
         chk("d1_busy",  c, busy0,  eb[0][c]);
         chk("d1_out",   c, out0,   eo[0][c]);
         chk("d4_valid", c, valid1, ev[1][c]);
         chk("d4_ferr",  c, ferr1,  ef[1][c]);
         chk("d4_busy",  c, busy1,  eb[1][c]);
         chk("d4_out",   c, out1,   eo[1][c]);
         chk("s2_valid", c, valid2, ev[2][c]);
         chk("s2_ferr",  c, ferr2,  ef[2][c]);
         chk("s2_busy",  c, busy2,  eb[2][c]);
         chk("s2_out",   c, out2,   eo[2][c]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   function automatic bit rb_bit(input logic [7:0] v, input int i);
      return v[i];
   endfunction

endmodule
